// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises board reset release, then releases NUM_STAGES
// active-low downstream resets one at a time in index order. A soft-reset
// request (or, optionally, a watchdog timeout) re-runs the same sequence.
// Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned STAGE_DLY  = 16,
    parameter int unsigned SOFT_HOLD  = 8,
    parameter int unsigned WDT_W      = 20
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  all_ready,
    input  logic                  soft_req,
    output logic                  soft_ack,
    output logic                  busy,
    input  logic                  wdt_kick,
    output logic                  wdt_fired
);

    typedef enum logic [1:0] {
        StHold,
        StSeq,
        StRun,
        StSoft
    } state_e;

    // One shared counter times both the stage gaps and the soft hold.
    localparam int unsigned CntMax = (STAGE_DLY > SOFT_HOLD) ? STAGE_DLY : SOFT_HOLD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DLY - 1);
    localparam logic [CntW-1:0] SoftLast  = CntW'(SOFT_HOLD - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_STAGES - 1);

    logic [1:0]            sync_q;
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ack_q, ack_d;
    logic                  wdt_timeout;
    logic                  soft_go;

    // Two-flop synchroniser for the release of resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign soft_go = soft_req | wdt_timeout;

    // Next-state logic: sequencing, soft hold and stage release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ack_d   = 1'b0;
        unique case (state_q)
            StHold: begin
                // Leave HOLD on the edge where the synchroniser output rises.
                if (sync_q[0] && !sync_q[1]) begin
                    state_d = StSeq;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            StSeq: begin
                if (cnt_q == StageLast) begin
                    stage_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    if (idx_q == IdxLast) begin
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (soft_go) begin
                    stage_d = '0;
                    cnt_d   = '0;
                    state_d = StSoft;
                end
            end
            StSoft: begin
                if (cnt_q == SoftLast) begin
                    ack_d   = 1'b1;
                    state_d = StSeq;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StHold;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    // Timeout fires on the edge the counter would reach all-ones.
    localparam logic [WDT_W-1:0] WdtPre = {WDT_W{1'b1}} - WDT_W'(1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             fired_q, fired_d;

    // A kick on the timeout edge wins over the timeout.
    assign wdt_timeout = (state_q == StRun) && !wdt_kick && (wdt_q == WdtPre);

    // Watchdog counter runs only in RUN; cleared on entry and on kick.
    always_comb begin
        wdt_d   = wdt_q;
        fired_d = fired_q;
        if ((state_d == StRun) && (state_q != StRun)) begin
            wdt_d = '0;
        end else if (state_q == StRun) begin
            if (wdt_kick) begin
                wdt_d = '0;
            end else begin
                wdt_d = wdt_q + WDT_W'(1);
            end
        end
        if (wdt_timeout) begin
            fired_d = 1'b1;
        end
    end

    // Watchdog registers; wdt_fired is only cleared by resetn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fired_q <= fired_d;
        end
    end

    assign wdt_fired = fired_q;
`else
    logic unused_wdt;

    assign wdt_timeout = 1'b0;
    assign wdt_fired   = 1'b0;
    assign unused_wdt  = wdt_kick & (WDT_W > 0);
`endif

    assign stage_rstn = stage_q;
    assign all_ready  = &stage_q;
    assign busy       = (state_q != StRun);
    assign soft_ack   = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed literal checks plus a
// randomized run compared every cycle against a timeline-based model.
module tb_reset_sequencer;

    localparam int unsigned N      = 3;
    localparam int unsigned DLY    = 4;
    localparam int unsigned HOLD   = 8;
    localparam int unsigned WDTW   = 4;

    logic         clk;
    logic         resetn;
    logic [N-1:0] stage_rstn;
    logic         all_ready;
    logic         soft_req;
    logic         soft_ack;
    logic         busy;
    logic         wdt_kick;
    logic         wdt_fired;

    int n_checks = 0;
    int n_pass   = 0;

    reset_sequencer #(
        .NUM_STAGES (N),
        .STAGE_DLY  (DLY),
        .SOFT_HOLD  (HOLD),
        .WDT_W      (WDTW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .stage_rstn (stage_rstn),
        .all_ready  (all_ready),
        .soft_req   (soft_req),
        .soft_ack   (soft_ack),
        .busy       (busy),
        .wdt_kick   (wdt_kick),
        .wdt_fired  (wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: a sequence that started at edge S has released
    // min(N, (e-S)/DLY) stages at edge e. A soft reset started at edge T
    // restarts the sequence at edge T+HOLD with an ack on that edge.
    int m_e;          // edges since resetn release
    int m_seq_start;  // edge the current sequence began, -1 if none
    int m_soft_start; // edge the current soft hold began, -1 if none
    int m_rel = 0;    // stages released
    int m_rcnt;       // kick-free RUN edges
    bit m_ack = 1'b0;
    bit m_fired = 1'b0;

    function automatic int released_at(input int e, input int s);
        int k;
        if (s < 0) return 0;
        k = (e - s) / int'(DLY);
        return (k > int'(N)) ? int'(N) : k;
    endfunction

    initial begin
        bit was_run;
        bit timeout;
        m_e = 0; m_seq_start = -1; m_soft_start = -1; m_rcnt = 0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_e = 0; m_seq_start = -1; m_soft_start = -1; m_rcnt = 0;
                m_rel = 0; m_ack = 1'b0; m_fired = 1'b0;
            end else begin
                was_run = (m_rel == int'(N));
                m_e++;
                m_ack = 1'b0;
                timeout = 1'b0;
                if (m_e == 2) m_seq_start = 2;
                if (was_run) begin
`ifdef RESET_SEQ_WDT_EN
                    if (wdt_kick) begin
                        m_rcnt = 0;
                    end else begin
                        m_rcnt++;
                        if (m_rcnt == (1 << WDTW) - 1) timeout = 1'b1;
                    end
`endif
                    if (soft_req || timeout) begin
                        m_soft_start = m_e;
                        m_seq_start  = -1;
                        if (timeout) m_fired = 1'b1;
                    end
                end else if (m_soft_start >= 0 && m_e == m_soft_start + int'(HOLD)) begin
                    m_ack        = 1'b1;
                    m_seq_start  = m_e;
                    m_soft_start = -1;
                end
                m_rel = released_at(m_e, m_seq_start);
                if (m_rel == int'(N) && !was_run) m_rcnt = 0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_stage;
        exp_stage = N'((1 << m_rel) - 1);
        chk("model_stage", stage_rstn, exp_stage);
        chk("model_all_ready", all_ready, (m_rel == int'(N)));
        chk("model_busy", busy, (m_rel != int'(N)));
        chk("model_soft_ack", soft_ack, m_ack);
        chk("model_wdt_fired", wdt_fired, m_fired);
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn   = 1'b0;
        soft_req = 1'b0;
        wdt_kick = 1'b0;
        step(5);
        chk("rst_stage", stage_rstn, 3'b000);
        chk("rst_busy", busy, 1'b1);
        chk("rst_all_ready", all_ready, 1'b0);
        chk("rst_soft_ack", soft_ack, 1'b0);
        chk("rst_wdt_fired", wdt_fired, 1'b0);

        // Power-on sequence; a request during SEQ at edge 8 must be ignored.
        resetn = 1'b1;
        step(5);
        chk("pwr_e5", stage_rstn, 3'b000);
        step(1);
        chk("pwr_e6", stage_rstn, 3'b001);
        step(1);
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        step(2);
        chk("pwr_e10", stage_rstn, 3'b011);
        step(3);
        chk("pwr_e13", stage_rstn, 3'b011);
        chk("pwr_e13_busy", busy, 1'b1);
        step(1);
        chk("pwr_e14", stage_rstn, 3'b111);
        chk("pwr_e14_ready", all_ready, 1'b1);
        chk("pwr_e14_busy", busy, 1'b0);

        // Soft reset pulse at edge t.
        soft_req = 1'b1;
        step(1);
        soft_req = 1'b0;
        chk("soft_t_stage", stage_rstn, 3'b000);
        chk("soft_t_busy", busy, 1'b1);
        chk("soft_t_ready", all_ready, 1'b0);
        step(7);
        chk("soft_t7_ack", soft_ack, 1'b0);
        step(1);
        chk("soft_t8_ack", soft_ack, 1'b1);
        chk("soft_t8_stage", stage_rstn, 3'b000);
        step(1);
        chk("soft_t9_ack", soft_ack, 1'b0);
        step(2);
        chk("soft_t11", stage_rstn, 3'b000);
        step(1);
        chk("soft_t12", stage_rstn, 3'b001);
        step(4);
        chk("soft_t16", stage_rstn, 3'b011);
        step(4);
        chk("soft_t20", stage_rstn, 3'b111);
        chk("soft_t20_busy", busy, 1'b0);

`ifdef RESET_SEQ_WDT_EN
        // No kick: timeout after 15 RUN cycles.
        step(14);
        chk("wdt_e14_stage", stage_rstn, 3'b111);
        chk("wdt_e14_fired", wdt_fired, 1'b0);
        step(1);
        chk("wdt_e15_stage", stage_rstn, 3'b000);
        chk("wdt_e15_fired", wdt_fired, 1'b1);
        step(HOLD + N * DLY);
        chk("wdt_reseq", stage_rstn, 3'b111);
        // Kicks every 10 cycles keep it in RUN.
        for (int i = 0; i < 6; i++) begin
            step(9);
            wdt_kick = 1'b1;
            step(1);
            wdt_kick = 1'b0;
            chk("wdt_kick_ready", all_ready, 1'b1);
        end
        chk("wdt_sticky", wdt_fired, 1'b1);
`else
        // Without the watchdog, a long kick-free RUN changes nothing.
        step(60);
        chk("nowdt_stage", stage_rstn, 3'b111);
        chk("nowdt_fired", wdt_fired, 1'b0);
        chk("nowdt_busy", busy, 1'b0);
`endif

        // Mid-sequence asynchronous reset at edge 11.
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(11);
        chk("mid_e11", stage_rstn, 3'b011);
        resetn = 1'b0;
        #1;
        chk("mid_async_stage", stage_rstn, 3'b000);
        chk("mid_async_ready", all_ready, 1'b0);
        chk("mid_async_busy", busy, 1'b1);
        step(1);
        resetn = 1'b1;
        step(14);
        chk("mid_reseq", stage_rstn, 3'b111);
        chk("mid_reseq_fired", wdt_fired, 1'b0);

        // Randomized phase checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            soft_req = ($urandom_range(0, 11) == 0) || (soft_req && ($urandom_range(0, 3) != 0));
            wdt_kick = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 399) == 0) begin
                resetn = 1'b0;
                step($urandom_range(1, 3));
                resetn = 1'b1;
            end
            step(1);
        end
        soft_req = 1'b0;
        wdt_kick = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
